// File: rtl/sc1_loop_stack_if.sv
// sc1_loop_stack_if
// Bundles the fetch-side signals exchanged between the sc1 core and its
// nested zero-overhead loop controller.
//
// Signals (core -> loop stack):
//   pc            current fetch address
//   pc_en         fetch advances this cycle
//   loop_start    push a new loop context (one-cycle pulse)
//   loop_count    extra iterations (N -> body runs N+1 times)
//   loop_end      absolute address of the last body instruction
//   loop_span     signed offset added to pc on loop-back (mod 2**DEPTH_I)
//   loop_break    pop the top context immediately
// Signals (loop stack -> core):
//   next_pc       next fetch address when the core is not branching
//   active        at least one context is valid
//   level         number of valid contexts
//   full          stack holds NEST contexts
//   err_overflow  sticky: push attempted while full
//   err_nest      sticky: pushed end address not inside the enclosing loop
// Modports: master = core side, slave = loop stack side.

interface sc1_loop_stack_if #(
    parameter int DEPTH_I   = 8,
    parameter int WIDTH_C   = 32,
    parameter int NEST_BITS = 3
);
    logic [DEPTH_I-1:0]   pc;
    logic                 pc_en;
    logic                 loop_start;
    logic [WIDTH_C-1:0]   loop_count;
    logic [DEPTH_I-1:0]   loop_end;
    logic [DEPTH_I-1:0]   loop_span;
    logic                 loop_break;
    logic [DEPTH_I-1:0]   next_pc;
    logic                 active;
    logic [NEST_BITS-1:0] level;
    logic                 full;
    logic                 err_overflow;
    logic                 err_nest;

    modport master (
        output pc, pc_en, loop_start, loop_count, loop_end, loop_span, loop_break,
        input  next_pc, active, level, full, err_overflow, err_nest
    );

    modport slave (
        input  pc, pc_en, loop_start, loop_count, loop_end, loop_span, loop_break,
        output next_pc, active, level, full, err_overflow, err_nest
    );
endinterface

// File: rtl/sc1_loop_stack.sv
// sc1_loop_stack
// Nested zero-overhead loop controller for the sc1 core family. Keeps a stack
// of up to NEST loop contexts (remaining count, end address, loop-back span)
// and produces the next fetch address every cycle so loop bodies run without
// branch overhead.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high; aborts all contexts and clears errors
//   bus    sc1_loop_stack_if.slave (pc/pc_en/loop_* in, next_pc/status out)
//
// Only the top context is ever compared against pc. Within one cycle a match
// decrement or pop is resolved first, then a break (which replaces any match
// action with a single pop), then a push above whatever remains.

module sc1_loop_stack #(
    parameter int DEPTH_I   = 8,
    parameter int WIDTH_C   = 32,
    parameter int NEST      = 4,
    parameter int NEST_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    sc1_loop_stack_if.slave      bus
);
    localparam int IDX_W = (NEST > 1) ? $clog2(NEST) : 1;
    localparam logic [NEST_BITS-1:0] NEST_L = NEST_BITS'(NEST);

    logic [WIDTH_C-1:0]   count_q [NEST];
    logic [DEPTH_I-1:0]   end_q   [NEST];
    logic [DEPTH_I-1:0]   span_q  [NEST];

    logic [NEST_BITS-1:0] level_q;
    logic                 err_overflow_q;
    logic                 err_nest_q;

    logic [IDX_W-1:0]     top_idx;
    logic [WIDTH_C-1:0]   top_count;
    logic [DEPTH_I-1:0]   top_end;
    logic [DEPTH_I-1:0]   top_span;
    logic                 has_ctx;
    logic                 match;
    logic                 count_nz;

    logic                 do_break;
    logic                 do_dec;
    logic                 do_pop;
    logic [NEST_BITS-1:0] level_mid;
    logic [IDX_W-1:0]     below_idx;
    logic [IDX_W-1:0]     push_idx;
    logic                 push_ok;
    logic                 push_over;
    logic                 nest_bad;
    logic [NEST_BITS-1:0] level_d;

    // Top-of-stack view and loop-back decision. When the stack is empty the
    // top index wraps to a stale entry, but has_ctx masks every use of it.
    always_comb begin
        top_idx   = IDX_W'(level_q - 1'b1);
        top_count = count_q[top_idx];
        top_end   = end_q[top_idx];
        top_span  = span_q[top_idx];
        has_ctx   = (level_q != '0);
        match     = has_ctx && (bus.pc == top_end);
        count_nz  = (top_count != '0);
        if (match && count_nz && !bus.loop_break) begin
            bus.next_pc = bus.pc + top_span;
        end else begin
            bus.next_pc = bus.pc + DEPTH_I'(1);
        end
    end

    // Resolve this cycle's stack action. A break on a non-empty stack is the
    // only pop for the cycle and suppresses any decrement from a match; the
    // push decisions are then made against the post-pop level.
    always_comb begin
        do_break  = bus.loop_break && has_ctx;
        do_dec    = bus.pc_en && match && count_nz && !bus.loop_break;
        do_pop    = do_break || (bus.pc_en && match && !count_nz);
        level_mid = do_pop ? (level_q - 1'b1) : level_q;
        below_idx = IDX_W'(level_mid - 1'b1);
        push_idx  = IDX_W'(level_mid);
        push_over = bus.loop_start && (level_mid == NEST_L);
        push_ok   = bus.loop_start && (level_mid != NEST_L);
        nest_bad  = push_ok && (level_mid != '0) && (bus.loop_end >= end_q[below_idx]);
        level_d   = push_ok ? (level_mid + 1'b1) : level_mid;
    end

    // Stack depth and sticky error flags; the only state touched by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q        <= '0;
            err_overflow_q <= 1'b0;
            err_nest_q     <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push_over) begin
                err_overflow_q <= 1'b1;
            end
            if (nest_bad) begin
                err_nest_q <= 1'b1;
            end
        end
    end

    // Context storage. Contents above level are don't-care, so no reset. A
    // decrement targets the old top while a push targets one slot above it,
    // so both can land in the same cycle without colliding.
    always_ff @(posedge clk) begin
        if (do_dec) begin
            count_q[top_idx] <= top_count - WIDTH_C'(1);
        end
        if (push_ok) begin
            count_q[push_idx] <= bus.loop_count;
            end_q[push_idx]   <= bus.loop_end;
            span_q[push_idx]  <= bus.loop_span;
        end
    end

    assign bus.active       = (level_q != '0);
    assign bus.level        = level_q;
    assign bus.full         = (level_q == NEST_L);
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_nest     = err_nest_q;

endmodule
